// File: rtl/io_uart.sv
// io_uart: memory-mapped UART with a transmit FIFO, a single-byte receive buffer
// and a programmable baud divisor, on a 4-byte bus window.
module io_uart #(
  parameter logic [15:0] BASE_ADDR   = 16'h1000,
  parameter logic [15:0] DEFAULT_DIV = 16'd103,
  parameter int          TX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dMemIOAddress,
  input  logic [7:0]  dMemIOIn,
  input  logic        dMemIOWriteEn,
  input  logic        dMemIOReadEn,
  output logic [7:0]  dataOut,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_state, tx_next, rx_state, rx_next;
  logic [15:0] div, tx_cnt, tx_per, rx_cnt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0] mem [TX_DEPTH];
  logic [7:0] tx_sh, rx_sh, rx_buf, rd_mux;
  logic [2:0] tx_bit, rx_bit;
  logic rx_s1, rx_s2, rx_d, rx_valid, rx_overrun;
  logic sel, empty, full, push, pop, tx_tick, rx_tick, rx_half, rx_done, rd_data, rd_stat;
  assign sel     = dMemIOAddress[15:2] == BASE_ADDR[15:2];
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a pop in the same cycle frees a slot, so a write to a full FIFO still lands
  assign push    = sel && dMemIOWriteEn && dMemIOAddress[1:0] == 2'd0 && (!full || pop);
  assign rd_data = sel && dMemIOReadEn && dMemIOAddress[1:0] == 2'd0;
  assign rd_stat = sel && dMemIOReadEn && dMemIOAddress[1:0] == 2'd1;
  assign tx_tick = tx_cnt == tx_per;
  assign rx_tick = rx_cnt == div;
  assign rx_half = rx_cnt == {1'b0, div[15:1]};
  assign tx      = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
  assign irq     = rx_valid;
  assign rd_mux  = dMemIOAddress[1:0] == 2'd0 ? rx_buf :
                   dMemIOAddress[1:0] == 2'd1 ? {4'b0, rx_overrun, rx_valid, tx_state == IDLE && empty, full} :
                   dMemIOAddress[1:0] == 2'd2 ? div[7:0] : div[15:8];
  always_comb begin
    tx_next = tx_state;
    pop = 1'b0;
    case (tx_state)
      IDLE:  if (!empty) begin tx_next = START; pop = 1'b1; end
      START: if (tx_tick) tx_next = DATA;
      DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = STOP;
      STOP:  if (tx_tick) begin tx_next = empty ? IDLE : START; pop = !empty; end
      default: tx_next = IDLE;
    endcase
  end
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      IDLE:  if (rx_d && !rx_s2) rx_next = START;
      START: if (rx_half) rx_next = rx_s2 ? IDLE : DATA;
      DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = STOP;
      STOP:  if (rx_tick) begin rx_next = IDLE; rx_done = rx_s2; end
      default: rx_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      rx_state <= IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= dMemIOIn;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_sh <= 8'h00;
      tx_cnt <= 16'd0;
      tx_per <= DEFAULT_DIV;
      tx_bit <= 3'd0;
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d <= 1'b1;
      rx_cnt <= 16'd0;
      rx_bit <= 3'd0;
      rx_sh <= 8'h00;
      rx_buf <= 8'h00;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
      div <= DEFAULT_DIV;
      dataOut <= 8'h00;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d <= rx_s2;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        tx_sh <= mem[rd_ptr[AW-1:0]];
      end else if (tx_state == DATA && tx_tick) tx_sh <= {1'b0, tx_sh[7:1]};
      // the bit period is sampled at each bit boundary so divisor writes never split a bit
      tx_cnt <= (tx_state == IDLE || tx_tick) ? 16'd0 : tx_cnt + 16'd1;
      if (tx_state == IDLE || tx_tick) tx_per <= div;
      tx_bit <= tx_state != DATA ? 3'd0 : tx_tick ? tx_bit + 3'd1 : tx_bit;
      rx_cnt <= (rx_state == IDLE || (rx_state == START && rx_half) || rx_tick) ? 16'd0 : rx_cnt + 16'd1;
      rx_bit <= rx_state != DATA ? 3'd0 : rx_tick ? rx_bit + 3'd1 : rx_bit;
      if (rx_state == DATA && rx_tick) rx_sh <= {rx_s2, rx_sh[7:1]};
      if (rx_done) rx_buf <= rx_sh;
      rx_valid <= rx_done || (rx_valid && !rd_data);
      rx_overrun <= (rx_done && rx_valid && !rd_data) || (rx_overrun && !rd_stat);
      if (sel && dMemIOWriteEn && dMemIOAddress[1:0] == 2'd2) div[7:0] <= dMemIOIn;
      if (sel && dMemIOWriteEn && dMemIOAddress[1:0] == 2'd3) div[15:8] <= dMemIOIn;
      if (dMemIOReadEn) dataOut <= sel ? rd_mux : 8'h00;
    end
  end
endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: directed and randomized checks of io_uart against a frame-level model.
module tb_io_uart;
  logic clk = 1'b0, rst_n = 1'b0, we = 1'b0, re = 1'b0, rx = 1'b1, tx, irq;
  logic [15:0] addr = 16'h0000;
  logic [7:0] din = 8'h00, dout, v;
  int n_assert = 0, n_fail = 0;
  bit logging = 1'b0;
  logic tx_log[$];
  logic [7:0] exp_bytes[$];

  io_uart dut (.clk(clk), .rst_n(rst_n), .dMemIOAddress(addr), .dMemIOIn(din),
               .dMemIOWriteEn(we), .dMemIOReadEn(re), .dataOut(dout), .tx(tx), .rx(rx), .irq(irq));

  always #5 clk = ~clk;
  always @(negedge clk) if (logging) tx_log.push_back(tx);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // all bus tasks start and end on a falling clock edge
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = dout;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] e);
    logic [7:0] r;
    rd(a, r);
    chk8(tag, r, e);
  endtask

  task automatic set_div(input logic [15:0] d);
    wr(16'h1002, d[7:0]);
    wr(16'h1003, d[15:8]);
  endtask

  task automatic rx_send(input logic [7:0] b, input int per, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = f[0];
      f = f >> 1;
      repeat (per) @(negedge clk);
    end
    rx = 1'b1;
    repeat (per + 4) @(negedge clk);
  endtask

  // expected line: start(0), 8 data bits LSB first, stop(1), per cycles each, frames back to back
  task automatic check_tx(input string tag, input int per);
    int s, bad, idx, last;
    logic e;
    logic [7:0] bv;
    s = -1;
    for (int i = 0; i < tx_log.size(); i++)
      if (tx_log[i] === 1'b0) begin s = i; break; end
    chk({tag, " start found"}, s >= 0 ? 1 : 0, 1);
    if (s < 0) return;
    for (int f = 0; f < exp_bytes.size(); f++) begin
      bv = exp_bytes[f];
      bad = 0;
      for (int k = 0; k < 10; k++) begin
        e = k == 0 ? 1'b0 : k == 9 ? 1'b1 : bv[3'(k - 1)];
        for (int c = 0; c < per; c++) begin
          idx = s + (f * 10 + k) * per + c;
          if (idx >= tx_log.size() || tx_log[idx] !== e) bad++;
        end
      end
      chk($sformatf("%s frame %0d bad cycles", tag, f), bad, 0);
    end
    last = s + exp_bytes.size() * 10 * per;
    bad = tx_log.size() - last < per ? 1 : 0;
    for (int i = last; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) bad++;
    chk({tag, " idle after frames"}, bad, 0);
  endtask

  initial begin
    int d, w;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk1("reset tx", tx, 1'b1);
    chk8("reset dataOut", dout, 8'h00);
    chk1("reset irq", irq, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("reset status", 16'h1001, 8'h02);
    rd_chk("reset div lo", 16'h1002, 8'h67);
    rd_chk("reset div hi", 16'h1003, 8'h00);
    set_div(16'd3);
    addr = 16'h1002; din = 8'h09; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    chk8("read+write returns old", dout, 8'h03);
    rd_chk("read+write new value", 16'h1002, 8'h09);
    wr(16'h1002, 8'h03);
    wr(16'h2002, 8'hFF);
    rd_chk("unselected write ignored", 16'h1002, 8'h03);
    rd_chk("unselected read", 16'h2001, 8'h00);
    wr(16'h1001, 8'hFF);
    rd_chk("status write ignored", 16'h1001, 8'h02);

    tx_log.delete(); exp_bytes = {8'h55}; logging = 1'b1;
    wr(16'h1000, 8'h55);
    repeat (50) @(negedge clk);
    logging = 1'b0;
    check_tx("tx 55", 4);
    rd_chk("status after tx", 16'h1001, 8'h02);

    tx_log.delete(); exp_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; logging = 1'b1;
    for (int i = 1; i <= 6; i++) wr(16'h1000, 8'(i));
    rd_chk("status fifo full", 16'h1001, 8'h01);
    repeat (220) @(negedge clk);
    logging = 1'b0;
    check_tx("burst", 4);
    rd_chk("status after burst", 16'h1001, 8'h02);

    rx_send(8'hA3, 4, 1'b1);
    chk1("irq after rx", irq, 1'b1);
    rd_chk("status rx valid", 16'h1001, 8'h06);
    rd_chk("rx data A3", 16'h1000, 8'hA3);
    chk1("irq after read", irq, 1'b0);

    rx_send(8'h11, 4, 1'b1);
    rx_send(8'h22, 4, 1'b1);
    rd_chk("status overrun", 16'h1001, 8'h0E);
    rd_chk("rx data overwritten", 16'h1000, 8'h22);
    rd_chk("status overrun cleared", 16'h1001, 8'h02);

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("status after glitch", 16'h1001, 8'h02);
    rx_send(8'h5A, 4, 1'b0);
    rd_chk("status after bad stop", 16'h1001, 8'h02);
    chk1("irq after bad stop", irq, 1'b0);

    for (int it = 0; it < 4; it++) begin
      d = $urandom_range(2, 7);
      set_div(16'(d));
      rd_chk($sformatf("rand %0d div lo", it), 16'h1002, 8'(d));
      b = 8'($urandom);
      tx_log.delete(); exp_bytes = {b}; logging = 1'b1;
      wr(16'h1000, b);
      repeat (12 * (d + 1) + 10) @(negedge clk);
      logging = 1'b0;
      check_tx($sformatf("rand %0d tx", it), d + 1);
      b = 8'($urandom);
      rx_send(b, d + 1, 1'b1);
      rd_chk($sformatf("rand %0d status", it), 16'h1001, 8'h06);
      rd_chk($sformatf("rand %0d rx data", it), 16'h1000, b);
    end

    set_div(16'd3);
    rd_chk("status before reset", 16'h1001, 8'h02);
    wr(16'h1000, 8'h55);
    w = 0;
    while (tx !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("reset test start seen", w < 20 ? 1 : 0, 1);
    repeat (18) @(negedge clk);
    chk1("tx bit3 before reset", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("tx async reset", tx, 1'b1);
    chk8("dataOut async reset", dout, 8'h00);
    chk1("irq async reset", irq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk1("tx idle after reset", tx, 1'b1);
    rd_chk("status after reset", 16'h1001, 8'h02);
    rd_chk("div lo after reset", 16'h1002, 8'h67);
    rd_chk("div hi after reset", 16'h1003, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/io_uart.md
IO_UART -- requirements
Module: io_uart

Interface
REQ-001 Parameter BASE_ADDR, default 16'h1000: base of the 4-byte register window on the data memory/IO bus.
REQ-002 Parameter DEFAULT_DIV, default 16'd103: reset value of the baud divisor.
REQ-003 Parameter TX_DEPTH, default 4: transmit FIFO depth in bytes (power of two).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 dMemIOAddress  input  16  bus address from the CPU.
REQ-007 dMemIOIn  input  8  write data from the CPU.
REQ-008 dMemIOWriteEn  input  1  bus write strobe, one cycle per access.
REQ-009 dMemIOReadEn  input  1  bus read strobe, one cycle per access.
REQ-010 dataOut  output  8  registered read data; 8'h00 when not selected.
REQ-011 tx  output  1  serial transmit line, idle high.
REQ-012 rx  input  1  serial receive line, asynchronous to clk.
REQ-013 irq  output  1  high while the receive buffer holds unread data.

Function
REQ-014 The block SHALL be selected only when dMemIOAddress[15:2] == BASE_ADDR[15:2]; offset = dMemIOAddress[1:0].
REQ-015 Register map SHALL be: 0 DATA (W: push TX, R: pop RX); 1 STATUS (RO); 2 DIV_LO (RW); 3 DIV_HI (RW).
REQ-016 STATUS SHALL read {4'b0, rxOverrun, rxValid, txIdle, txFull}; txIdle = FIFO empty and shifter idle.
REQ-017 Read latency SHALL be one cycle: dataOut is valid on the cycle after dMemIOReadEn and holds until the next selected read; an unselected read loads 8'h00.
REQ-018 Selected write to DATA with FIFO not full SHALL push the byte; with FIFO full the write SHALL be dropped, leaving the FIFO unchanged.
REQ-019 Writes to STATUS SHALL be ignored; writes to DIV_LO/DIV_HI SHALL update that byte of the divisor the next cycle.
REQ-020 Read of DATA SHALL return the RX buffer and clear rxValid; read of STATUS SHALL clear rxOverrun after returning it.
REQ-021 Simultaneous readEn and writeEn SHALL perform both; write takes effect and the read returns the pre-write value.
REQ-022 Bit period SHALL be (divisor + 1) clk cycles; a divisor change applies from the next bit boundary.
REQ-023 TX FSM SHALL have states IDLE, START, DATA, STOP: IDLE->START when FIFO non-empty (pop same cycle); START (tx=0, 1 bit)->DATA; DATA sends 8 bits LSB first->STOP; STOP (tx=1, 1 bit)->START if FIFO non-empty, else IDLE.
REQ-024 FIFO pointers SHALL be log2(TX_DEPTH)+1 bits, wrapping modulo 2*TX_DEPTH; full/empty derived from MSB compare; a push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-025 rx SHALL pass through a 2-flop synchronizer before use.
REQ-026 RX FSM SHALL have states IDLE, START, DATA, STOP: falling edge in IDLE->START; sample at half bit period; if sampled high, return to IDLE (glitch); else sample 8 data bits at mid-bit, LSB first; STOP samples stop bit.
REQ-027 At STOP with stop bit high the byte SHALL load the RX buffer and set rxValid; if rxValid was already set, the buffer SHALL be overwritten and rxOverrun set; a low stop bit SHALL discard the byte without flagging.
REQ-028 A DATA read in the same cycle a new byte completes SHALL return the old byte; rxValid remains set for the new byte.
REQ-029 irq SHALL equal rxValid.

Reset
REQ-030 While rst_n is low: tx=1, dataOut=8'h00, irq=0, FIFO empty, rxValid=0, rxOverrun=0, divisor=DEFAULT_DIV, both FSMs IDLE, synchronizer flops at 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, tx returning high asynchronously.

Verification
REQ-032 Write 8'h55 to 0x1000 with DIV=3 -> tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 of 4 cycles each, then high 4 cycles; STATUS then reads 8'h02.
REQ-033 Five back-to-back DATA writes 8'h01..8'h05 while idle -> first byte goes to the shifter, the other four fill the FIFO; STATUS bit0=1; no byte dropped; frames contiguous with no idle gap.
REQ-034 Drive frame 8'hA3 on rx at DIV=3 -> rxValid=1, irq=1; DATA read returns 8'hA3 next cycle; irq=0 afterwards.
REQ-035 Two frames 8'h11, 8'h22 without a read -> STATUS reads 8'h0E|txIdle bits, i.e. 8'h0E; DATA returns 8'h22; second STATUS read shows bit3=0.
REQ-036 rx low pulse of 1 cycle in idle -> no rxValid; frame with low stop bit -> no rxValid, no overrun.
REQ-037 Assert rst_n low during TX data bit 3 -> tx=1 immediately; after release, STATUS=8'h02 and DIV reads back DEFAULT_DIV.
